// File: rtl/cpu_ctl_seq.sv
// cpu_ctl_seq: 8-step fetch/execute sequencer with registered datapath strobes for the 8-bit RISC CPU.
module cpu_ctl_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       inc_pc,
  output logic       load_acc,
  output logic       load_pc,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       datactl_ena,
  output logic       halt,
  output logic [2:0] state
);
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_t;
  state_t     cur, nxt;
  logic       run, run_n, halted, halted_n, act;
  logic [2:0] op_q, op_n;
  logic       alu, skz, sto, jmp;
  logic       inc_pc_n, load_acc_n, load_pc_n, rd_n, wr_n, load_ir_n, dctl_n;
  // run marks an instruction in flight; while clear, the first enabled edge enters S0 rather than advancing
  always_comb begin
    nxt      = cur;
    run_n    = run;
    halted_n = halted;
    op_n     = op_q;
    act      = ena && !halted;
    if (halted) nxt = S3;
    else if (!ena) begin
      nxt   = S0;
      run_n = 1'b0;
    end else begin
      nxt   = run ? state_t'(cur + 3'd1) : S0;
      run_n = 1'b1;
    end
    if (act && nxt == S3) begin
      op_n     = opcode;
      halted_n = opcode == OP_HLT;
    end
    alu        = op_n inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
    skz        = op_n == OP_SKZ;
    sto        = op_n == OP_STO;
    jmp        = op_n == OP_JMP;
    inc_pc_n   = act && (nxt inside {S0, S1, S3} || (nxt == S5 && (jmp || (skz && zero))) || (nxt == S7 && skz && zero));
    rd_n       = act && (nxt inside {S0, S1} || (alu && nxt inside {S4, S5, S6}));
    load_ir_n  = act && nxt inside {S0, S1};
    load_acc_n = act && alu && nxt == S5;
    load_pc_n  = act && jmp && nxt inside {S4, S5};
    wr_n       = act && sto && nxt == S5;
    dctl_n     = act && sto && nxt inside {S4, S5, S6};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur         <= S0;
      run         <= 1'b0;
      halted      <= 1'b0;
      op_q        <= 3'd0;
      inc_pc      <= 1'b0;
      load_acc    <= 1'b0;
      load_pc     <= 1'b0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      load_ir     <= 1'b0;
      datactl_ena <= 1'b0;
      halt        <= 1'b0;
    end else begin
      cur         <= nxt;
      run         <= run_n;
      halted      <= halted_n;
      op_q        <= op_n;
      inc_pc      <= inc_pc_n;
      load_acc    <= load_acc_n;
      load_pc     <= load_pc_n;
      rd          <= rd_n;
      wr          <= wr_n;
      load_ir     <= load_ir_n;
      datactl_ena <= dctl_n;
      halt        <= halted_n;
    end
  end
  assign state = cur;
endmodule
